// File: rtl/v850_fetch_pkg.sv
// Shared types and helpers for the V850 instruction prefetch path.
package v850_fetch_pkg;

  localparam int unsigned PC_W    = 25;
  localparam int unsigned HW_W    = 16;
  localparam int unsigned LINE_HW = 4;
  localparam int unsigned LINE_W  = HW_W * LINE_HW;

  typedef logic [HW_W-1:0] hword_t;
  typedef logic [PC_W-1:0] pc_t;

  // One 64-bit memory line; element k is halfword k (little-endian).
  typedef hword_t [LINE_HW-1:0] line_t;

  // Instruction word as presented to the decoder.
  typedef struct packed {
    hword_t hi;
    hword_t lo;
  } inst_word_t;

  // Line fetch control: idle, waiting for a response, or waiting to drop one.
  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_WAIT  = 2'd1,
    FS_STALE = 2'd2
  } fetch_state_t;

  // V850 format: bits [10:9] == 2'b11 in the first halfword marks a 32-bit instruction.
  function automatic logic is_inst32(input logic [15:0] hw);
    return hw[10:9] == 2'b11;
  endfunction

endpackage

// File: rtl/inst_hw_ring.sv
// Circular halfword buffer: up to LINE_HW writes and two reads per cycle, with flush.
module inst_hw_ring
  import v850_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [2:0]               wr_cnt_i,
  input  line_t                    wr_data_i,
  input  logic [1:0]               rd_cnt_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output hword_t                   head0_c_o,
  output hword_t                   head1_c_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  hword_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer and occupancy update; flush wins over any push/pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_cnt_i);
    rd_ptr_d = rd_ptr_q + AW'(rd_cnt_i);
    count_d  = count_q + CW'(wr_cnt_i) - CW'(rd_cnt_i);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage: writes land at consecutive slots starting at the tail.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (!flush_i) begin
      for (int unsigned i = 0; i < LINE_HW; i++) begin
        if (3'(i) < wr_cnt_i) begin
          mem_q[wr_ptr_q + AW'(i)] <= wr_data_i[i];
        end
      end
    end
  end

  assign count_o   = count_q;
  assign head0_c_o = mem_q[rd_ptr_q];
  assign head1_c_o = mem_q[rd_ptr_q + AW'(1)];

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_ni)
    count_d <= CW'(DEPTH));
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_ni)
    flush_i || (CW'(rd_cnt_i) <= count_q));

endmodule

// File: rtl/inst_prefetch_queue.sv
// Prefetch queue: fetches 64-bit lines, buffers halfwords and hands out
// aligned 16/32-bit V850 instructions with their halfword PC.
module inst_prefetch_queue
  import v850_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter pc_t         RESET_PC = 25'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  output logic            fetch_req_o,
  output logic [PC_W-1:0] fetch_addr_o,
  input  logic            fetch_valid_i,
  input  logic [63:0]     fetch_data_i,
  output logic            inst_valid_o,
  output logic [31:0]     inst_o,
  output logic            inst_len32_o,
  output logic [PC_W-1:0] inst_pc_o,
  input  logic            inst_ready_i
);

  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam int unsigned ROOM_MAX = DEPTH - LINE_HW;

  fetch_state_t fst_q, fst_d;
  pc_t          line_addr_q, line_addr_d;
  pc_t          addr_q, addr_d;
  pc_t          pc_q, pc_d;
  logic [1:0]   skip_q, skip_d;
  logic         req_q, req_d;

  logic [CW-1:0] count;
  hword_t        head0, head1;
  logic          head_is32_c;
  logic          inst_valid_c;
  logic          pop_c;
  logic [1:0]    pop_len_c;
  logic          push_c;
  logic [2:0]    wr_cnt_c;
  line_t         wr_data_c;
  inst_word_t    inst_word_c;

  inst_hw_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk       (clk),
    .rst_ni    (reset),
    .flush_i   (redirect_i),
    .wr_cnt_i  (wr_cnt_c),
    .wr_data_i (wr_data_c),
    .rd_cnt_i  (pop_c ? pop_len_c : 2'd0),
    .count_o   (count),
    .head0_c_o (head0),
    .head1_c_o (head1)
  );

  // Head decode: an instruction is presentable only once all its halfwords are buffered.
  always_comb begin
    head_is32_c  = is_inst32(head0);
    pop_len_c    = head_is32_c ? 2'd2 : 2'd1;
    inst_valid_c = !redirect_i && (count != '0) &&
                   (!head_is32_c || (count >= CW'(2)));
    pop_c        = inst_valid_c && inst_ready_i;
    inst_word_c.lo = head0;
    inst_word_c.hi = head_is32_c ? head1 : '0;
  end

  // Push path: drop the leading halfwords that precede the target PC within the line.
  always_comb begin
    wr_cnt_c  = push_c ? (3'(LINE_HW) - 3'(skip_q)) : 3'd0;
    wr_data_c = line_t'(fetch_data_i >> {skip_q, 4'b0000});
  end

  // Fetch control and PC tracking; redirect overrides everything else.
  always_comb begin
    fst_d       = fst_q;
    line_addr_d = line_addr_q;
    addr_d      = addr_q;
    pc_d        = pc_q;
    skip_d      = skip_q;
    req_d       = 1'b0;
    push_c      = 1'b0;

    unique case (fst_q)
      FS_IDLE: begin
        // Registered count is used, so a same-cycle pop never earns extra room.
        if (!redirect_i && (count <= CW'(ROOM_MAX))) begin
          req_d       = 1'b1;
          addr_d      = line_addr_q;
          line_addr_d = line_addr_q + PC_W'(LINE_HW);
          fst_d       = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (fetch_valid_i) begin
          fst_d  = FS_IDLE;
          push_c = !redirect_i;
        end
      end
      FS_STALE: begin
        if (fetch_valid_i) begin
          fst_d = FS_IDLE;
        end
      end
      default: fst_d = FS_IDLE;
    endcase

    if (push_c) begin
      skip_d = 2'd0;
    end
    if (pop_c) begin
      pc_d = pc_q + PC_W'(pop_len_c);
    end

    if (redirect_i) begin
      pc_d        = redirect_pc_i;
      line_addr_d = {redirect_pc_i[PC_W-1:2], 2'b00};
      skip_d      = redirect_pc_i[1:0];
      if ((fst_q == FS_WAIT) && !fetch_valid_i) begin
        fst_d = FS_STALE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fst_q       <= FS_IDLE;
      line_addr_q <= {RESET_PC[PC_W-1:2], 2'b00};
      addr_q      <= {RESET_PC[PC_W-1:2], 2'b00};
      pc_q        <= RESET_PC;
      skip_q      <= RESET_PC[1:0];
      req_q       <= 1'b0;
    end else begin
      fst_q       <= fst_d;
      line_addr_q <= line_addr_d;
      addr_q      <= addr_d;
      pc_q        <= pc_d;
      skip_q      <= skip_d;
      req_q       <= req_d;
    end
  end

  assign fetch_req_o  = req_q;
  assign fetch_addr_o = addr_q;
  assign inst_valid_o = inst_valid_c;
  assign inst_o       = inst_valid_c ? inst_word_c : 32'h0;
  assign inst_len32_o = inst_valid_c && head_is32_c;
  assign inst_pc_o    = pc_q;

  a_line_aligned : assert property (@(posedge clk) disable iff (!reset)
    fetch_addr_o[1:0] == 2'b00);
  a_req_pulse : assert property (@(posedge clk) disable iff (!reset)
    fetch_req_o |=> !fetch_req_o);

endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
- Sits between instruction memory and the decoder side of IFetcher.
- Issues 64-bit line fetches and buffers the returned halfwords in a ring.
- Splits the V850 stream into aligned 16/32-bit instructions and presents one per cycle with valid/ready, tagged with its halfword PC.
- Flushes and refetches on branch redirect.

Parameters:
- DEPTH, 16: queue capacity in halfwords; power of two, >= 8.
- RESET_PC, 25'h0: halfword address fetched after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-low reset (0 = reset).
- redirect_i  in  1  flush the queue and restart fetch at redirect_pc_i.
- redirect_pc_i  in  25  halfword target address.
- fetch_req_o  out  1  line fetch request, one-cycle pulse.
- fetch_addr_o  out  25  halfword address of the line; bits [1:0] always 0.
- fetch_valid_i  in  1  line data valid, arriving 1 or more cycles after the request.
- fetch_data_i  in  64  line data; halfword k = bits [16k+15:16k], little-endian.
- inst_valid_o  out  1  complete instruction at head of queue.
- inst_o  out  32  {second halfword, first halfword}; bits [31:16] = 0 for 16-bit instructions.
- inst_len32_o  out  1  1 = 32-bit instruction.
- inst_pc_o  out  25  halfword PC of inst_o.
- inst_ready_i  in  1  consumer accepts the instruction.

Behaviour:
- Reset (reset=0 at posedge):
  - Queue emptied, outstanding flag and stale flag cleared.
  - Fetch line address = {RESET_PC[24:2],2'b00}; skip count = RESET_PC[1:0]; inst_pc = RESET_PC.
  - Outputs: fetch_req_o=0, inst_valid_o=0, inst_o=0, inst_len32_o=0, inst_pc_o=RESET_PC.
- Length rule: head halfword bits [10:9]==2'b11 means 32-bit, otherwise 16-bit.
- inst_valid_o (combinational from registered state) =
  - count>=1 for a 16-bit head, or count>=2 for a 32-bit head;
  - forced to 0 while redirect_i=1.
- Pop: on inst_valid_o & inst_ready_i, pop 1 or 2 halfwords and advance inst_pc by 1 or 2.
- Request:
  - fetch_req_o=1 for one cycle when there is no outstanding request and free slots >= 4.
  - Only one request may be outstanding.
  - fetch_addr_o is held until the response arrives.
  - Line address advances by 4 when the request is issued; it wraps modulo 2^25.
- Push:
  - On fetch_valid_i with the stale flag clear, write halfwords skip..3 at the tail in order.
  - skip is then cleared to 0.
  - The outstanding flag clears.
  - The data is visible at the head on the next cycle; with 1-cycle memory, req to inst_valid_o is 2 cycles.
- Push and pop in the same cycle are both performed; count is updated by the net amount.
- Free-space check uses the count after that cycle's pop is excluded, i.e. the registered count (conservative).
- Redirect (highest priority):
  - Queue cleared; any pop or push in that cycle is discarded.
  - inst_pc = redirect_pc_i; line address = {redirect_pc_i[24:2],2'b00}; skip = redirect_pc_i[1:0].
  - If a request is outstanding, the stale flag is set. The next fetch_valid_i is dropped and clears both flags. No new request is issued until then.
- Redirect in the same cycle as fetch_valid_i: that data is dropped and no stale flag is set.
- 32-bit instruction straddling two lines: held (valid=0) until the second line is pushed.
- Full queue: no request is issued; no halfword is ever overwritten or lost.
- fetch_valid_i without an outstanding request is ignored.

Decomposition:
- Package v850_fetch_pkg:
  - PC_W=25, HW_W=16, LINE_HW=4.
  - Function is_inst32(logic[15:0]) implementing the length rule.
  - Typedefs hword_t and pc_t.
- Sub-module inst_hw_ring (DEPTH parameter):
  - Circular halfword buffer with up to 4 writes and up to 2 reads per cycle, plus a flush input.
  - Outputs count and the two head halfwords.
- Top level holds the fetch control, skip/stale logic and length split.

Test Plan:
- Memory model with 1-cycle latency holding hw0..9 = 11C1,125F,2141,1EC1,000B,49E1,0000,0000,0000,0000; reset low 5 cycles, then released with inst_ready_i=1:
  - first fetch_addr_o=0;
  - instructions in order (inst_o/pc): 000011C1/0, 0000125F/1, 00002141/2, 000B1EC1/3 (len32=1, straddles lines 0 and 1), 000049E1/5, 00000000/6.
- Same memory, redirect_i with redirect_pc_i=5 while the queue is non-empty:
  - next fetch_addr_o=4;
  - first instruction after the flush is 000049E1 at pc 5; no pre-redirect instruction appears after the redirect cycle.
- inst_ready_i=0 for 20 cycles: count saturates at 16; fetch_req_o stays 0 after the 4th line.
- On release, instructions continue at pc 0 with nothing lost or duplicated.
- Memory latency raised to 3 cycles; redirect to pc 2 one cycle after a request:
  - the stale response is dropped; the next request is issued only after it returns, with fetch_addr_o=0;
  - first instruction output is 00002141 at pc 2.
- Reset asserted mid-stream with an outstanding request:
  - all outputs return to reset values; the late response is ignored;
  - restart fetches from address 0 and outputs 000011C1 at pc 0.
